// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port, variable-latency memory between the
//                core's instruction fetch and load/store paths. One access is
//                granted at a time; completion and read data are returned to
//                the owning requester, and the core is stalled until every
//                pending request has completed.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                if_req/if_addr        - fetch request (held until if_rvalid)
//                if_rvalid/if_rdata    - fetch completion pulse and instruction
//                d_req/d_we/d_be/d_addr/d_wdata - data request (held until d_rvalid)
//                d_rvalid/d_rdata      - data completion pulse and load data
//                bus_err               - completion was forced by a timeout
//                stall                 - hold PC / writeback
//                mem_*                 - external memory port
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_STREAK_MAX = 4,
    parameter int TIMEOUT         = 255,
    parameter int TO_W            = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int               SW           = (DATA_STREAK_MAX < 2) ? 1 : $clog2(DATA_STREAK_MAX + 1);
    localparam logic [SW-1:0]    C_STREAK_MAX = SW'(DATA_STREAK_MAX);
    localparam logic [TO_W-1:0]  C_TIMEOUT    = TO_W'(TIMEOUT);
    localparam logic             C_TO_EN      = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_streak;
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_busy;
    logic              w_grant_d;
    logic              w_grant_f;
    logic              w_to_hit;
    logic              w_done;
    logic [31:0]       w_rdata;

    // Data normally wins; once it has taken DATA_STREAK_MAX grants in a row
    // while a fetch is waiting, the fetch gets the next slot.
    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_grant_d = d_req & (~if_req | (r_streak != C_STREAK_MAX));
        w_grant_f = if_req & ~w_grant_d;
        w_to_hit  = C_TO_EN & w_busy & (r_to_cnt == C_TIMEOUT);
        // mem_ready in the timeout cycle still counts as a normal completion
        w_done    = w_busy & (mem_ready | w_to_hit);
        w_rdata   = mem_ready ? mem_rdata : 32'h0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = ST_DATA;
                end else if (w_grant_f) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_streak  <= '0;
            r_to_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
                if (w_grant_d) begin
                    mem_we    <= d_we;
                    mem_be    <= d_be;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    // Streak only matters while a fetch is actually waiting
                    if (!if_req) begin
                        r_streak <= '0;
                    end else if (r_streak != C_STREAK_MAX) begin
                        r_streak <= r_streak + SW'(1);
                    end
                end else if (w_grant_f) begin
                    mem_we    <= 1'b0;
                    mem_be    <= 4'hF;
                    mem_addr  <= if_addr;
                    mem_wdata <= 32'h0;
                    r_streak  <= '0;
                end
            end else if (!mem_ready && (r_to_cnt != C_TIMEOUT)) begin
                // Saturating: with the timeout disabled the counter never moves
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    // Only the owner of the current access sees completion and data
    always_comb begin
        mem_req   = w_busy;
        if_rvalid = (r_state == ST_FETCH) & w_done;
        d_rvalid  = (r_state == ST_DATA) & w_done;
        if_rdata  = if_rvalid ? w_rdata : 32'h0;
        d_rdata   = d_rvalid ? w_rdata : 32'h0;
        bus_err   = w_done & ~mem_ready;
        stall     = (if_req & ~if_rvalid) | (d_req & ~d_rvalid);
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed scenarios
//                followed by randomized traffic against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .DATA_STREAK_MAX (MAXS),
        .TIMEOUT         (TMO),
        .TO_W            (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .bus_err   (bus_err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) begin
            errors++;
            $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h, want all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_rvalid, d_rvalid, bus_err, stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset_out: got ifv=%b dv=%b err=%b stall=%b, want 0000",
                     if_rvalid, d_rvalid, bus_err, stall);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        if_req  = 1'b1;
        if_addr = 32'h100;
        #1;
        checks++;
        if ({stall, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_req_cycle: got stall=%b mem_req=%b, want 1 0", stall, mem_req);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
                errors++;
                $display("FAIL fetch_mem[%0d]: got req=%b we=%b be=%h addr=%h, want 1 0 f 00000100",
                         k, mem_req, mem_we, mem_be, mem_addr);
            end
            checks++;
            if ({if_rvalid, stall} !== 2'b01) begin
                errors++;
                $display("FAIL fetch_wait[%0d]: got rvalid=%b stall=%b, want 0 1", k, if_rvalid, stall);
            end
            tick();
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h00500093;
        #1;
        checks++;
        if ({if_rvalid, if_rdata, stall, bus_err, d_rvalid} !== {1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_done: got rvalid=%b rdata=%h stall=%b err=%b dv=%b, want 1 00500093 0 0 0",
                     if_rvalid, if_rdata, stall, bus_err, d_rvalid);
        end
        tick();
        if_req    = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req, if_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_after: got mem_req=%b rvalid=%b, want 0 0", mem_req, if_rvalid);
        end
        tick();
    endtask

    task automatic test_store();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h2000;
        d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_early: got d_rvalid=%b, want 0", d_rvalid);
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD0BAD;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL store_mem: got req=%b we=%b be=%h addr=%h wdata=%h, want 1 1 3 00002000 deadbeef",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if ({d_rvalid, d_rdata, bus_err, if_rvalid, if_rdata} !== {1'b1, 32'h0BAD0BAD, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL store_done: got dv=%b drdata=%h err=%b ifv=%b ifrdata=%h, want 1 0bad0bad 0 0 0",
                     d_rvalid, d_rdata, bus_err, if_rvalid, if_rdata);
        end
        tick();
        d_req     = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({mem_req, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL store_after: got mem_req=%b dv=%b, want 0 0", mem_req, d_rvalid);
        end
        tick();
    endtask

    task automatic test_streak();
        int  grants;
        bit  prev_req;
        bit  got_f;
        bit  want_f;
        grants    = 0;
        prev_req  = 1'b0;
        if_addr   = 32'h100;
        d_addr    = 32'h3000;
        d_we      = 1'b0;
        d_be      = 4'hF;
        if_req    = 1'b1;
        d_req     = 1'b1;
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
            mem_rdata = 32'h1000 + 32'(cyc);
            #1;
            checks++;
            if (mem_req && prev_req) begin
                errors++;
                $display("FAIL streak_gap: got mem_req high two cycles in a row at cycle %0d, want an idle cycle", cyc);
            end
            if (mem_req) begin
                got_f  = (mem_addr == 32'h100);
                want_f = ((grants % 5) == 4);
                checks++;
                if ({got_f, if_rvalid, d_rvalid} !== {want_f, want_f, ~want_f}) begin
                    errors++;
                    $display("FAIL streak_grant[%0d]: got fetch=%b ifv=%b dv=%b, want fetch=%b",
                             grants, got_f, if_rvalid, d_rvalid, want_f);
                end
                grants++;
            end
            prev_req = mem_req;
            tick();
        end
        checks++;
        if (grants != 10) begin
            errors++;
            $display("FAIL streak_count: got %0d grants, want 10", grants);
        end
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            d_req     = 1'b1;
            d_we      = 1'b0;
            d_be      = 4'hF;
            d_addr    = 32'h44;
            mem_ready = 1'b0;
            mem_rdata = 32'hFFFFFFFF;
            tick();
            for (int k = 0; k < TMO; k++) begin
                #1;
                checks++;
                if ({mem_req, d_rvalid, bus_err} !== 3'b100) begin
                    errors++;
                    $display("FAIL timeout_wait[%0d/%0d]: got req=%b dv=%b err=%b, want 1 0 0",
                             pass, k, mem_req, d_rvalid, bus_err);
                end
                tick();
            end
            if (pass == 1) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h12345678;
            end
            #1;
            checks++;
            if (pass == 0 && {d_rvalid, bus_err, d_rdata} !== {1'b1, 1'b1, 32'h0}) begin
                errors++;
                $display("FAIL timeout_abort: got dv=%b err=%b rdata=%h, want 1 1 00000000",
                         d_rvalid, bus_err, d_rdata);
            end else if (pass == 1 && {d_rvalid, bus_err, d_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
                errors++;
                $display("FAIL timeout_ready_wins: got dv=%b err=%b rdata=%h, want 1 0 12345678",
                         d_rvalid, bus_err, d_rdata);
            end
            tick();
            d_req     = 1'b0;
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({mem_req, d_rvalid, bus_err} !== 3'b000) begin
                errors++;
                $display("FAIL timeout_idle[%0d]: got req=%b dv=%b err=%b, want 0 0 0",
                         pass, mem_req, d_rvalid, bus_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hC;
        d_addr  = 32'h80;
        d_wdata = 32'h55;
        tick();
        tick();
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got mem_req=%b, want 1", mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_rvalid, if_rvalid, bus_err, stall} !== 74'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got req=%b we=%b be=%h addr=%h wdata=%h dv=%b err=%b, want all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_rvalid, bus_err);
        end
        tick();
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        checks++;
        if ({mem_req, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_late: got mem_req=%b dv=%b, want 0 0", mem_req, d_rvalid);
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE;
        #1;
        checks++;
        if ({if_rvalid, if_rdata, mem_addr, mem_be} !== {1'b1, 32'hCAFE, 32'h40, 4'hF}) begin
            errors++;
            $display("FAIL rstmid_fetch: got ifv=%b rdata=%h addr=%h be=%h, want 1 0000cafe 00000040 f",
                     if_rvalid, if_rdata, mem_addr, mem_be);
        end
        tick();
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA5555;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({mem_req, if_rvalid, d_rvalid, bus_err, if_rdata, d_rdata} !== 68'h0) begin
                errors++;
                $display("FAIL idle_ready[%0d]: got req=%b ifv=%b dv=%b err=%b, want 0 0 0 0",
                         k, mem_req, if_rvalid, d_rvalid, bus_err);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    // Transaction-level model: one outstanding access with its owner, its
    // latched fields and how long it has waited for the memory.
    task automatic test_random();
        bit          m_busy, m_owner_d;
        int          m_age, m_streak;
        bit          m_we;
        logic [3:0]  m_be;
        logic [31:0] m_addr, m_wdata;
        bit          rq_f, rq_d;
        bit          e_fv, e_dv, e_done, e_err, e_stall;
        logic [31:0] e_rd;
        m_busy = 0; m_owner_d = 0; m_age = 0; m_streak = 0;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
        rq_f = 0; rq_d = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if_req    = rq_f;
            d_req     = rq_d;
            mem_ready = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            #1;
            e_fv    = m_busy && !m_owner_d && (mem_ready || m_age == TMO);
            e_dv    = m_busy && m_owner_d && (mem_ready || m_age == TMO);
            e_done  = e_fv || e_dv;
            e_rd    = (e_done && mem_ready) ? mem_rdata : 32'h0;
            e_err   = e_done && !mem_ready;
            e_stall = (rq_f && !e_fv) || (rq_d && !e_dv);
            checks++;
            if (mem_req !== m_busy) begin
                errors++;
                $display("FAIL rnd_req@%0d: got %b, want %b", cyc, mem_req, m_busy);
            end
            if (m_busy) begin
                checks++;
                if ({mem_we, mem_be, mem_addr} !== {m_we, m_be, m_addr} || (m_owner_d && mem_wdata !== m_wdata)) begin
                    errors++;
                    $display("FAIL rnd_fields@%0d: got we=%b be=%h addr=%h wdata=%h, want %b %h %h %h",
                             cyc, mem_we, mem_be, mem_addr, mem_wdata, m_we, m_be, m_addr, m_wdata);
                end
            end
            checks++;
            if ({if_rvalid, if_rdata, d_rvalid, d_rdata, bus_err, stall} !==
                {e_fv, (e_fv ? e_rd : 32'h0), e_dv, (e_dv ? e_rd : 32'h0), e_err, e_stall}) begin
                errors++;
                $display("FAIL rnd_resp@%0d: got ifv=%b ifd=%h dv=%b dd=%h err=%b stall=%b, want %b %h %b %h %b %b",
                         cyc, if_rvalid, if_rdata, d_rvalid, d_rdata, bus_err, stall,
                         e_fv, (e_fv ? e_rd : 32'h0), e_dv, (e_dv ? e_rd : 32'h0), e_err, e_stall);
            end
            // Advance the model across the clock edge
            if (m_busy) begin
                if (e_done) m_busy = 0;
                else        m_age++;
            end else if (rq_d && (!rq_f || m_streak < MAXS)) begin
                m_busy = 1; m_owner_d = 1; m_age = 0;
                m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
                m_streak = rq_f ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end else if (rq_f) begin
                m_busy = 1; m_owner_d = 0; m_age = 0;
                m_we = 0; m_be = 4'hF; m_addr = if_addr;
                m_streak = 0;
            end
            // Requesters hold their fields until served, then drop or reissue
            if ((e_fv && $urandom_range(0, 1) == 1) || (!rq_f && $urandom_range(0, 2) == 0)) begin
                rq_f    = 1;
                if_addr = {$urandom} & 32'hFFFF_FFFC;
            end else if (e_fv) begin
                rq_f = 0;
            end
            if ((e_dv && $urandom_range(0, 1) == 1) || (!rq_d && $urandom_range(0, 2) == 0)) begin
                rq_d    = 1;
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = 4'($urandom_range(0, 15));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if (e_dv) begin
                rq_d = 0;
            end
            tick();
        end
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_lone_fetch();
        test_store();
        test_streak();
        test_timeout();
        test_reset_mid();
        test_idle_ready();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one single-port, variable-latency memory shared by the single-stage core's instruction fetch and load/store paths.
- Grants one transaction at a time and returns read data and completion pulses to each requester.
- Drives a stall to the core so the PC and register writeback hold until both pending accesses complete.
- Sits between the datapath (pc, aluout, writedata, readdata) and the external memory.

Parameters:
DATA_STREAK_MAX, 4, max consecutive data grants while a fetch waits; the next grant then goes to fetch (min 1)
TIMEOUT, 255, cycles in a busy state without mem_ready before abort; 0 disables the timeout
TO_W, 8, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level; held with if_addr until if_rvalid
if_addr  in  32  fetch address (pc)
if_rvalid  out  1  fetch complete, 1-cycle pulse
if_rdata  out  32  instruction, valid with if_rvalid
d_req  in  1  data request, level; held with d_* until d_rvalid
d_we  in  1  1 = store
d_be  in  4  byte enables
d_addr  in  32  data address (aluout)
d_wdata  in  32  store data
d_rvalid  out  1  data access complete, 1-cycle pulse (loads and stores)
d_rdata  out  32  load data, valid with d_rvalid
bus_err  out  1  pulses with if_rvalid/d_rvalid when the access timed out
stall  out  1  (if_req & ~if_rvalid) | (d_req & ~d_rvalid)
mem_req  out  1  memory request, held high for the whole access
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_ready  in  1  memory completes the access this cycle; mem_rdata valid
mem_rdata  in  32  memory read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state: FSM in IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; mem_be = 0.
- Reset state: streak and timeout counters 0; if_rvalid, d_rvalid, bus_err = 0.
- Reset mid-access: mem_req is low the cycle after the reset edge. The in-flight access is abandoned with no rvalid.
- FSM states: IDLE, FETCH, DATA.
- IDLE arbitration:
  - Only if_req set -> FETCH.
  - Only d_req set -> DATA.
  - Both set -> DATA, unless streak == DATA_STREAK_MAX, in which case -> FETCH.
  - Neither set -> stay in IDLE.
- Granted-request latch: on the grant edge, the granted request's fields are registered into mem_*.
  - Fetch: mem_we = 0, mem_be = 4'hF, mem_addr = if_addr.
  - Data: mem_we = d_we, mem_be = d_be, mem_addr = d_addr, mem_wdata = d_wdata.
  - mem_* hold constant until the access ends.
- Streak counter:
  - +1 on each DATA grant, saturating at DATA_STREAK_MAX.
  - Cleared on each FETCH grant.
  - Also cleared on a DATA grant when if_req is low.
- FETCH/DATA states: mem_req = 1.
- Completion: in the cycle mem_ready = 1, the owner's rvalid = 1 combinationally and rdata = mem_rdata combinationally.
  - Next state is IDLE; mem_req drops next cycle.
  - Requester must drop or change req by the following edge.
- Latency: request seen in IDLE at cycle n -> mem_req high in n+1 -> rvalid in n+1 at the earliest (mem_ready in n+1). Minimum 2 cycles per access.
  - No back-to-back grant without passing through IDLE for one cycle.
- Non-owner outputs: rvalid = 0 and rdata = 0 for the requester not being served.
- Timeout (TIMEOUT != 0):
  - Counter clears on entry to FETCH/DATA and increments each busy cycle without mem_ready.
  - When it reaches TIMEOUT, that cycle the owner's rvalid = 1, rdata = 0 and bus_err = 1; next state is IDLE.
  - mem_ready arriving in that same cycle wins: normal completion, no error.
- Requester drops req mid-access (protocol violation): the access still completes and rvalid still pulses.
- mem_ready while in IDLE: ignored.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100; mem_ready rises 3 cycles after mem_req -> mem_addr=0x100, mem_be=F, mem_we=0; if_rvalid pulses with if_rdata=mem_rdata=0x00500093; stall high until then.
- Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready on first cycle -> mem_* match exactly; d_rvalid pulses at request cycle+1; bus_err=0.
- Arbitration streak: both requesters continuously re-request (DATA_STREAK_MAX=4) -> grant sequence D,D,D,D,F,D,D,D,D,F; each grant separated by one IDLE cycle.
- Timeout: TIMEOUT=5, mem_ready never asserted -> mem_req high 5 cycles, then d_rvalid=1, bus_err=1, d_rdata=0, return to IDLE; repeat with mem_ready on cycle 5 -> normal completion, bus_err=0.
- Reset mid-access: reset asserted during DATA -> next cycle mem_req=0, all outputs 0, no d_rvalid; a following fetch is served normally.
- Late ready: mem_ready pulsed in IDLE with no request -> no rvalid and no state change.
